sram_port_a_ctrl: RTL

- Bus-side initiator for port A (read/write port) of the team's synthesizable dual-port SRAM; port B remains a separate read-only path.
- Accepts single-beat read/write requests over a valid/ready handshake and drives the SRAM address, write data and write enable.
- The SRAM has no byte enables, so partial-byte writes are performed as read-modify-write (RMW).
- Returns one response pulse per request, with read data or an address-range error.

---
 rtl/sram_port_a_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sram_port_a_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_a_ctrl
// Brief    : Port-A bus initiator for the dual-port SRAM. It handles single-beat
//            read/write requests, with read-modify-write for partial writes.
// Revision : 1.0 - initial release
// ============================================================================
module sram_port_a_ctrl #(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int BE_WIDTH   = WIDTH / 8
) (
   input  logic                  clk_a,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0]      req_wdata,
   input  logic [BE_WIDTH-1:0]   req_be,
   output logic                  rsp_valid,
   output logic [WIDTH-1:0]      rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [WIDTH-1:0]      sram_wdata,
   output logic                  sram_we,
   input  logic [WIDTH-1:0]      sram_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_RMW     = 2'd2
   } state_t;

   // One extra bit lets a non-power-of-two DEPTH be compared without wrapping.
   localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH+1)'(DEPTH);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr_q;
   logic [WIDTH-1:0]      r_wdata_q;
   logic [BE_WIDTH-1:0]   r_be_q;
   logic                  r_rsp_valid;
   logic                  r_rsp_err;
   logic [WIDTH-1:0]      r_rsp_rdata;

   logic                  w_oor;
   logic                  w_be_full;
   logic                  w_be_none;
   logic                  w_latch;
   logic                  w_we;
   logic                  w_rsp_valid_nxt;
   logic                  w_rsp_err_nxt;
   logic [WIDTH-1:0]      w_rsp_rdata_nxt;
   logic [WIDTH-1:0]      w_merged;

   assign w_oor     = ({1'b0, req_addr} >= c_depth);
   assign w_be_full = &req_be;
   assign w_be_none = ~|req_be;

   for (genvar i = 0; i < BE_WIDTH; i++) begin : g_lane
      assign w_merged[8*i +: 8] = r_be_q[i] ? r_wdata_q[8*i +: 8] : sram_rdata[8*i +: 8];
   end

   always_comb begin
      w_state_nxt     = r_state;
      req_ready       = 1'b0;
      sram_addr       = req_addr;
      sram_wdata      = req_wdata;
      w_we            = 1'b0;
      w_latch         = 1'b0;
      w_rsp_valid_nxt = 1'b0;
      w_rsp_err_nxt   = 1'b0;
      w_rsp_rdata_nxt = r_rsp_rdata;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (w_oor) begin
                  w_rsp_valid_nxt = 1'b1;
                  w_rsp_err_nxt   = 1'b1;
                  w_rsp_rdata_nxt = '0;
               end else if (!req_we) begin
                  w_latch     = 1'b1;
                  w_state_nxt = ST_RD_WAIT;
               end else if (w_be_full || w_be_none) begin
                  // Zero-enable writes are acknowledged without touching the array.
                  w_we            = w_be_full;
                  w_rsp_valid_nxt = 1'b1;
               end else begin
                  w_latch     = 1'b1;
                  w_state_nxt = ST_RMW;
               end
            end
         end
         ST_RD_WAIT: begin
            sram_addr       = r_addr_q;
            sram_wdata      = w_merged;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_rdata_nxt = sram_rdata;
            w_state_nxt     = ST_IDLE;
         end
         ST_RMW: begin
            sram_addr       = r_addr_q;
            sram_wdata      = w_merged;
            w_we            = 1'b1;
            w_rsp_valid_nxt = 1'b1;
            w_state_nxt     = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Reset gates the strobe directly, so an in-flight RMW cannot commit.
   assign sram_we = w_we & ~rst;

   always_ff @(posedge clk_a or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_addr_q    <= '0;
         r_wdata_q   <= '0;
         r_be_q      <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
         if (w_latch) begin
            r_addr_q  <= req_addr;
            r_wdata_q <= req_wdata;
            r_be_q    <= req_be;
         end
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_err   = r_rsp_err;
   assign rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire
